instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end stage directly upstream of the ALU/regfile/RAM datapath: holds the PC, fetches
//  one 32-bit instruction word at a time from instruction memory over a req/ack handshake,
//  and presents it to decode with a valid/ready handshake. The next PC is computed only when
//  the current instruction is consumed, from the datapath's PCsrc, eq, ImmOp and ALUout
//  (non-speculative). PCplus4 feeds the jal/jalr link write.
// PARAMETERS
//  Data_Width         32  PC/instruction/immediate width
//  Address_Width_ROM  12  byte-address width driven to instruction memory
//  RESET_PC           0   PC loaded on reset; must be 4-byte aligned
// PORTS
//  clk         in   1                  clock, all state updates on rising edge
//  rst_n       in   1                  reset: one clock, synchronous, active-low
//  imem_req    out  1                  fetch request to instruction memory
//  imem_addr   out  Address_Width_ROM  fetch byte address = PC[Address_Width_ROM-1:0]
//  imem_ack    in   1                  memory returns imem_rdata this cycle
//  imem_rdata  in   Data_Width         instruction word
//  instr_valid out  1                  Instr/PC/PCplus4 valid for decode
//  instr_ready in   1                  decode/datapath consumes instruction this cycle
//  Instr       out  Data_Width         captured instruction
//  PC          out  Data_Width         address of Instr
//  PCplus4     out  Data_Width         PC + 4 (modulo 2^Data_Width)
//  PCsrc       in   2                  00 seq, 01 branch-if-eq, 10 jal, 11 jalr
//  eq          in   1                  ALU equality flag for consumed branch
//  ImmOp       in   Data_Width         sign-extended offset for branch/jal
//  ALUout      in   Data_Width         jalr target (rs1 + imm)
//  misalign    out  1                  sticky: computed target not 4-byte aligned
// BEHAVIOUR
//  States: IDLE -> REQ -> HOLD -> REQ ... ; ERR terminal until reset.
//  Reset (rst_n=0 at edge, any state, any handshake in flight): state=IDLE, PC=RESET_PC,
//   Instr=0, instr_valid=0, imem_req=0, misalign=0. PCplus4 = PC+4 always (combinational).
//  IDLE: one cycle, imem_req=0; any imem_ack here is ignored; next REQ.
//  REQ: imem_req=1, imem_addr held stable until ack. On imem_ack: Instr<=imem_rdata,
//   instr_valid<=1, go HOLD. Request latency is unbounded; no timeout.
//  HOLD: imem_req=0, Instr/PC held stable while instr_valid=1 and instr_ready=0.
//   On instr_ready: instr_valid<=0 in the same edge; PC<=target:
//    00: PC+4   01: eq ? PC+ImmOp : PC+4   10: PC+ImmOp   11: ALUout & ~1
//   All adds are Data_Width wrap-around. If target[1:0]!=0: PC unchanged, misalign<=1,
//   go ERR; else go REQ.
//  Fetch-to-valid latency: min 1 cycle after request issue (ack same cycle as req) ->
//   instr_valid high next cycle. Back-to-back throughput: consume->REQ->HOLD = 2 cycles min.
//  ERR: imem_req=0, instr_valid=0, misalign=1; only rst_n exits.
//  imem_ack outside REQ is ignored; instr_ready outside HOLD is ignored.
// STRUCTURE
//  riscv_pkg: typedef enum logic[1:0] pcsrc_t {PC_SEQ,PC_BEQ,PC_JAL,PC_JALR};
//   typedef enum fetch_state_t {F_IDLE,F_REQ,F_HOLD,F_ERR}; localparam INSTR_BYTES=4.
//  Sub-module next_pc_calc: combinational target + misalign check from PC, PCsrc, eq,
//   ImmOp, ALUout. FSM, PC and Instr registers stay in instr_fetch_unit.
// TESTING
//  1 rst_n low 2 cycles, RESET_PC=0 -> imem_req=0 during reset, imem_addr=0 and req=1
//    one cycle after IDLE; ack rdata=32'h00500093 -> Instr=32'h00500093, PC=0, valid=1.
//  2 sequential, instr_ready held 1, ack after 3 cycles each -> PC 0,4,8; valid never
//    high while req high; Instr stable while ready=0 for 5 cycles.
//  3 PC=0x10, PCsrc=01, ImmOp=-8: eq=1 -> next imem_addr=0x08; eq=0 -> 0x14.
//  4 PC=0x20, PCsrc=11, ALUout=0x101 -> PC=0x100; ALUout=0x102 -> misalign=1, ERR,
//    req stays 0 for 10 cycles, rst_n clears it.
//  5 PC=32'hFFFFFFFC, PCsrc=00 -> PC wraps to 0, PCplus4 at 0xFFFFFFFC equals 0.
//  6 rst_n low while in REQ, ack arrives during reset and in IDLE -> ignored, no valid,
//    fresh fetch at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction fetch front-end
package riscv_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BEQ,
        PC_JAL,
        PC_JALR
    } pcsrc_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_HOLD,
        F_ERR
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem req/ack, decode valid/ready and next-PC control bundle
interface instr_fetch_unit_if #(
    parameter int Data_Width        = 32,
    parameter int Address_Width_ROM = 12
);
    logic                         imem_req;
    logic [Address_Width_ROM-1:0] imem_addr;
    logic                         imem_ack;
    logic [Data_Width-1:0]        imem_rdata;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [Data_Width-1:0]        Instr;
    logic [Data_Width-1:0]        PC;
    logic [Data_Width-1:0]        PCplus4;
    logic [1:0]                   PCsrc;
    logic                         eq;
    logic [Data_Width-1:0]        ImmOp;
    logic [Data_Width-1:0]        ALUout;
    logic                         misalign;

    modport master (
        output imem_req, imem_addr, instr_valid, Instr, PC, PCplus4, misalign,
        input  imem_ack, imem_rdata, instr_ready, PCsrc, eq, ImmOp, ALUout
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, Instr, PC, PCplus4, misalign,
        output imem_ack, imem_rdata, instr_ready, PCsrc, eq, ImmOp, ALUout
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// rtl/instr_fetch_unit_next_pc_calc.sv - combinational next-PC target and alignment check
module next_pc_calc
    import riscv_pkg::*;
#(
    parameter int Data_Width = 32
) (
    input  logic [Data_Width-1:0] pc_i,
    input  logic [1:0]            pcsrc_i,
    input  logic                  eq_i,
    input  logic [Data_Width-1:0] imm_i,
    input  logic [Data_Width-1:0] alu_i,
    output logic [Data_Width-1:0] target_o,
    output logic                  misalign_o
);
    logic [Data_Width-1:0] seq_pc;
    logic [Data_Width-1:0] rel_pc;

    assign seq_pc = pc_i + Data_Width'(INSTR_BYTES);
    assign rel_pc = pc_i + imm_i;

    always_comb begin
        target_o = seq_pc;
        unique case (pcsrc_t'(pcsrc_i))
            PC_SEQ:  target_o = seq_pc;
            PC_BEQ:  target_o = eq_i ? rel_pc : seq_pc;
            PC_JAL:  target_o = rel_pc;
            PC_JALR: target_o = alu_i & {{(Data_Width-1){1'b1}}, 1'b0};
            default: target_o = seq_pc;
        endcase
    end

    // jalr clears bit 0 only, so bit 1 can still leave a half-word target
    assign misalign_o = |target_o[1:0];
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder, one-word imem fetch FSM and decode handshake
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    Data_Width        = 32,
    parameter int                    Address_Width_ROM = 12,
    parameter logic [Data_Width-1:0] RESET_PC          = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    fetch_state_t          state_q, state_d;
    logic [Data_Width-1:0] pc_q, pc_d;
    logic [Data_Width-1:0] instr_q, instr_d;
    logic [Data_Width-1:0] target;
    logic                  target_misalign;
    logic                  consume;

    next_pc_calc #(.Data_Width(Data_Width)) u_next_pc (
        .pc_i       (pc_q),
        .pcsrc_i    (bus.PCsrc),
        .eq_i       (bus.eq),
        .imm_i      (bus.ImmOp),
        .alu_i      (bus.ALUout),
        .target_o   (target),
        .misalign_o (target_misalign)
    );

    assign consume = (state_q == F_HOLD) && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            F_IDLE:  state_d = F_REQ;
            F_REQ:   if (bus.imem_ack) state_d = F_HOLD;
            F_HOLD:  if (bus.instr_ready) state_d = target_misalign ? F_ERR : F_REQ;
            F_ERR:   state_d = F_ERR;
            default: state_d = F_IDLE;
        endcase
    end

    // PC only advances on a consumed, aligned target; a bad target freezes it
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (consume && !target_misalign) pc_d = target;
        if ((state_q == F_REQ) && bus.imem_ack) instr_d = bus.imem_rdata;
    end

    always_comb begin
        bus.imem_req    = (state_q == F_REQ);
        bus.instr_valid = (state_q == F_HOLD);
        bus.misalign    = (state_q == F_ERR);
        bus.imem_addr   = pc_q[Address_Width_ROM-1:0];
        bus.Instr       = instr_q;
        bus.PC          = pc_q;
        bus.PCplus4     = pc_q + Data_Width'(INSTR_BYTES);
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    typedef struct {
        logic [1:0]  src;
        logic        eq;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[10];

    instr_fetch_unit_if #(.Data_Width(32), .Address_Width_ROM(12)) bus ();

    instr_fetch_unit #(.Data_Width(32), .Address_Width_ROM(12), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00500093 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_wait", {31'b0, bus.imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input int lat);
        logic [31:0] e;
        wait_req();
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("imem_addr", {20'b0, bus.imem_addr}, {20'b0, e[11:0]});
            for (int k = 0; k < lat; k++) begin
                check("valid_during_req", {31'b0, bus.instr_valid}, 32'd0);
                tick();
                check("req_held", {31'b0, bus.imem_req}, 32'd1);
            end
            bus.imem_rdata = mem(e);
            bus.imem_ack   = 1'b1;
            tick();
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'h0;
            check("valid_after_ack", {31'b0, bus.instr_valid}, 32'd1);
            check("req_in_hold", {31'b0, bus.imem_req}, 32'd0);
            check("instr", bus.Instr, mem(e));
            check("pc", bus.PC, e);
            check("pcplus4", bus.PCplus4, e + 32'd4);
        end
    endtask

    task automatic consume(input logic [1:0] src, input logic eqv, input logic [31:0] imm,
                           input logic [31:0] alu, input logic [31:0] exp_pc,
                           input int hold, input bit err);
        logic [31:0] i0, p0;
        i0 = bus.Instr;
        p0 = bus.PC;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("instr_stable", bus.Instr, i0);
            check("pc_stable", bus.PC, p0);
            check("valid_stable", {31'b0, bus.instr_valid}, 32'd1);
        end
        bus.PCsrc       = src;
        bus.eq          = eqv;
        bus.ImmOp       = imm;
        bus.ALUout      = alu;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("valid_after_consume", {31'b0, bus.instr_valid}, 32'd0);
        check("pc_after_consume", bus.PC, exp_pc);
        check("misalign_flag", {31'b0, bus.misalign}, {31'b0, err});
        if (!err) exp_q.push_back(exp_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{PC_JALR, 1'b0, 32'h0,        32'h10,       32'h10};
        vecs[1] = '{PC_BEQ,  1'b1, 32'hFFFFFFF8, 32'h0,        32'h08};
        vecs[2] = '{PC_JALR, 1'b0, 32'h0,        32'h10,       32'h10};
        vecs[3] = '{PC_BEQ,  1'b0, 32'hFFFFFFF8, 32'h0,        32'h14};
        vecs[4] = '{PC_JAL,  1'b0, 32'h0C,       32'h0,        32'h20};
        vecs[5] = '{PC_JALR, 1'b0, 32'h0,        32'h101,      32'h100};
        vecs[6] = '{PC_JAL,  1'b0, 32'hFFFFFF00, 32'h0,        32'h0};
        vecs[7] = '{PC_JALR, 1'b0, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC};
        vecs[8] = '{PC_SEQ,  1'b0, 32'h0,        32'h0,        32'h0};
        vecs[9] = '{PC_JAL,  1'b0, 32'h20,       32'h0,        32'h20};

        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        bus.instr_ready = 1'b1;
        bus.PCsrc       = 2'b00;
        bus.eq          = 1'b0;
        bus.ImmOp       = 32'h0;
        bus.ALUout      = 32'h0;
        rst_n           = 1'b0;

        // reset with stray ack/ready, then the single IDLE cycle
        for (int k = 0; k < 2; k++) begin
            tick();
            check("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
        end
        check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.Instr, 32'h0);
        check("rst_pc", bus.PC, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        rst_n           = 1'b1;
        check("req_idle", {31'b0, bus.imem_req}, 32'd0);
        tick();
        check("req_after_idle", {31'b0, bus.imem_req}, 32'd1);
        exp_q.push_back(32'h0);
        do_fetch(0);

        consume(PC_SEQ, 1'b0, 32'h0, 32'h0, 32'h4, 5, 1'b0);
        do_fetch(3);
        consume(PC_SEQ, 1'b0, 32'h0, 32'h0, 32'h8, 0, 1'b0);
        do_fetch(3);

        for (int i = 0; i < 10; i++) begin
            consume(vecs[i].src, vecs[i].eq, vecs[i].imm, vecs[i].alu, vecs[i].exp_pc, i % 2, 1'b0);
            do_fetch(i % 3);
        end

        // misaligned jalr target from PC 0x20 is terminal until reset
        consume(PC_JALR, 1'b0, 32'h0, 32'h102, 32'h20, 0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            bus.imem_ack    = 1'b1;
            bus.instr_ready = 1'b1;
            tick();
            check("err_req", {31'b0, bus.imem_req}, 32'd0);
            check("err_sticky", {31'b0, bus.misalign}, 32'd1);
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        check("err_valid", {31'b0, bus.instr_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("err_cleared", {31'b0, bus.misalign}, 32'd0);
        check("err_rst_pc", bus.PC, 32'h0);
        rst_n = 1'b1;

        // reset while a request is outstanding, with ack landing in reset and IDLE
        tick();
        check("req_before_abort", {31'b0, bus.imem_req}, 32'd1);
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        tick();
        check("abort_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("abort_req", {31'b0, bus.imem_req}, 32'd0);
        check("abort_instr", bus.Instr, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_ack_ignored", {31'b0, bus.instr_valid}, 32'd0);
        check("refetch_req", {31'b0, bus.imem_req}, 32'd1);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_q.push_back(32'h0);
        do_fetch(1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
